// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared constants and types for the audio path (I2S DAC transmitter and the
// matching ADC receiver to come).
//   FRAME_SLOTS  : BCLK slots per I2S frame (both channels)
//   CHAN_SLOTS   : BCLK slots per channel
//   SAMPLE_W_DEF : default sample width
//   lrck_e       : word-select encoding, LEFT = 0, RIGHT = 1
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int FRAME_SLOTS  = 64;
  localparam int CHAN_SLOTS   = 32;
  localparam int SLOT_W       = $clog2(FRAME_SLOTS);
  localparam int CHAN_W       = $clog2(CHAN_SLOTS);
  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic {
    LRCK_LEFT  = 1'b0,
    LRCK_RIGHT = 1'b1
  } lrck_e;

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Small synchronous FIFO for audio samples with an asynchronous head read.
//   CLOCK_50 : clock
//   reset    : asynchronous, active-high; empties the FIFO
//   wr       : write strobe, ignored while full
//   wr_data  : data to store
//   rd       : pop strobe, ignored while empty
//   rd_data  : current head, combinational from the read pointer
//   full     : DEPTH entries stored
//   empty    : no entries stored
//   level    : number of stored entries
// -----------------------------------------------------------------------------
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]  wr_ptr;
  logic [ADDR_W:0]  rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers already
  // discards its contents, and an unreset array maps onto RAM.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[ADDR_W-1:0]];
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

endmodule

// File: rtl/audio_i2s_tx.sv
// -----------------------------------------------------------------------------
// audio_i2s_tx
// Mono I2S transmitter for the codec DAC (codec in slave mode). Samples are
// queued in a FIFO, one is popped per frame and sent on both channels.
//   CLOCK_50    : 50 MHz system clock
//   reset       : asynchronous, active-high
//   sample, wr  : sample input and one-cycle write strobe
//   full        : FIFO full; a wr while full is dropped
//   fifo_level  : stored samples
//   sample_req  : one-cycle pulse at each frame start
//   underflow   : one-cycle pulse when a frame starts with the FIFO empty
//   overflow    : one-cycle pulse when a wr is dropped
//   aud_bclk    : I2S bit clock
//   aud_daclrck : word select, 0 = left, 1 = right
//   aud_dacdat  : serial data, MSB first, one BCLK after the word-select edge
// -----------------------------------------------------------------------------
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int BCLK_DIV   = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [SAMPLE_W-1:0]           sample,
  input  logic                          wr,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sample_req,
  output logic                          underflow,
  output logic                          overflow,
  output logic                          aud_bclk,
  output logic                          aud_daclrck,
  output logic                          aud_dacdat
);

  localparam int CNT_W = $clog2(BCLK_DIV);

  logic [CNT_W-1:0]    div_cnt;
  logic [SLOT_W-1:0]   bit_cnt;
  logic [SAMPLE_W-1:0] hold;
  logic [SAMPLE_W-1:0] fifo_head;
  logic                fifo_empty;
  logic                div_tc;
  logic                fall_event;
  logic                frame_start;
  logic                pop;
  logic [SLOT_W-1:0]   next_slot;
  logic [CHAN_W-1:0]   chan_slot;
  logic                next_dat;

  assign div_tc      = (div_cnt == CNT_W'(BCLK_DIV - 1));
  // aud_bclk is about to go 1->0: the only moment serial outputs move.
  assign fall_event  = div_tc && aud_bclk;
  assign frame_start = fall_event && (bit_cnt == SLOT_W'(FRAME_SLOTS - 1));
  assign pop         = frame_start && !fifo_empty;

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .wr       (wr),
    .wr_data  (sample),
    .rd       (pop),
    .rd_data  (fifo_head),
    .full     (full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Data bit for the slot entered at the next fall event. Channel slot 0 is
  // the I2S one-BCLK delay; slots 1..SAMPLE_W carry the hold register MSB
  // first; the rest pad with 0. At frame start the slot is 0, so the hold
  // register update in that same cycle is never seen half-way.
  // NOTE: next_dat gets a default before the loop so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    next_slot = bit_cnt + 1'b1;
    chan_slot = next_slot[CHAN_W-1:0];
    next_dat  = 1'b0;
    for (int i = 1; i <= SAMPLE_W; i++) begin
      if (chan_slot == CHAN_W'(i)) next_dat = hold[SAMPLE_W-i];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      aud_bclk    <= 1'b0;
      bit_cnt     <= SLOT_W'(FRAME_SLOTS - 1);
      hold        <= '0;
      aud_daclrck <= LRCK_LEFT;
      aud_dacdat  <= 1'b0;
      sample_req  <= 1'b0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      underflow  <= 1'b0;
      // full is the pre-cycle state, so a same-cycle pop never makes room.
      overflow   <= wr && full;

      if (div_tc) begin
        div_cnt  <= '0;
        aud_bclk <= ~aud_bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (fall_event) begin
        bit_cnt     <= next_slot;
        aud_daclrck <= next_slot[SLOT_W-1] ? LRCK_RIGHT : LRCK_LEFT;
        aud_dacdat  <= next_dat;
      end

      if (frame_start) begin
        sample_req <= 1'b1;
        if (fifo_empty) underflow <= 1'b1;
        else            hold      <= fifo_head;
      end
    end
  end

endmodule
